// File: rtl/div_unit_32bit.sv
// Sequential radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One trial subtraction per cycle; valid/ready on both sides, one op in flight.
module div_unit_32bit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam int unsigned CntW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e            state_q, state_d;
   logic [XLEN:0]     r_q, r_d;
   logic [XLEN-1:0]   q_q, q_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              qsign_q, qsign_d;
   logic              rsign_q, rsign_d;
   logic              sel_rem_q, sel_rem_d;

   logic              signed_op, a_neg, b_neg, div_zero, ovf, special;
   logic [XLEN-1:0]   a_abs, b_abs, special_res, q_fix, r_fix;
   logic [XLEN:0]     r_sh, trial;

   // Operand decode and special-case detection at accept time
   always_comb begin
      signed_op   = ~op_i[0];
      a_neg       = signed_op & a_i[XLEN-1];
      b_neg       = signed_op & b_i[XLEN-1];
      a_abs       = a_neg ? -a_i : a_i;
      b_abs       = b_neg ? -b_i : b_i;
      div_zero    = (b_i == '0);
      ovf         = signed_op && (a_i == MinInt) && (b_i == '1);
      special     = div_zero | ovf;
      special_res = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : MinInt);
   end

   // Trial subtraction as an add of the inverted divisor with carry-in 1
   always_comb begin
      r_sh  = {r_q[XLEN-1:0], q_q[XLEN-1]};
      trial = r_sh + ~{1'b0, b_q} + {{XLEN{1'b0}}, 1'b1};
      q_fix = qsign_q ? -q_q : q_q;
      r_fix = rsign_q ? -r_q[XLEN-1:0] : r_q[XLEN-1:0];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (in_valid_i) state_d = special ? StDone : StCalc;
            StCalc:  if (cnt_q == '0) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      in_ready_o  = (state_q == StIdle);
      out_valid_o = (state_q == StDone);
      busy_o      = (state_q != StIdle);
      result_o    = result_q;
   end

   always_comb begin
      r_d       = r_q;
      q_d       = q_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      qsign_d   = qsign_q;
      rsign_d   = rsign_q;
      sel_rem_d = sel_rem_q;
      result_d  = result_q;
      if (!flush_i) begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  sel_rem_d = op_i[1];
                  if (special) begin
                     result_d = special_res;
                  end else begin
                     r_d     = '0;
                     q_d     = a_abs;
                     b_d     = b_abs;
                     cnt_d   = CntW'(XLEN - 1);
                     qsign_d = a_neg ^ b_neg;
                     rsign_d = a_neg;
                  end
               end
            end
            StCalc: begin
               r_d   = trial[XLEN] ? r_sh : trial;
               q_d   = {q_q[XLEN-2:0], ~trial[XLEN]};
               cnt_d = cnt_q - CntW'(1);
            end
            StFix:   result_d = sel_rem_q ? r_fix : q_fix;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_q       <= '0;
         q_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         qsign_q   <= 1'b0;
         rsign_q   <= 1'b0;
         sel_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         r_q       <= r_d;
         q_q       <= q_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         qsign_q   <= qsign_d;
         rsign_q   <= rsign_d;
         sel_rem_q <= sel_rem_d;
         result_q  <= result_d;
      end
   end

endmodule

// File: tb/tb_div_unit_32bit.sv
// Scoreboard bench for div_unit_32bit: directed vectors, a monitor checking results
// and completion cycle, plus backpressure, flush and async-reset scenarios.
module tb_div_unit_32bit;

   logic        clk = 1'b0;
   logic        reset_i, flush_i, in_valid_i, out_ready_i;
   logic [1:0]  op_i;
   logic [31:0] a_i, b_i;
   logic        in_ready_o, out_valid_o, busy_o;
   logic [31:0] result_o;

   div_unit_32bit #(.XLEN(32)) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op_i        (op_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          due;
      string       name;
   } exp_t;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   logic vld_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: first out_valid cycle and the result at handshake are both checked
   always @(negedge clk) begin
      if (out_valid_o && !vld_prev) begin
         if (sb.size() == 0) check("unexpected_out_valid", {31'b0, out_valid_o}, 32'd0);
         else check({sb[0].name, "_done_cycle"}, 32'(cyc), 32'(sb[0].due));
      end
      if (out_valid_o && out_ready_i && sb.size() != 0) begin
         check(sb[0].name, result_o, sb[0].res);
         void'(sb.pop_front());
      end
      vld_prev <= out_valid_o;
   end

   // Called at posedge+1 with the DUT expected in IDLE
   task automatic issue(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] res, input int lat,
                        input bit push);
      check({name, "_in_ready"}, {31'b0, in_ready_o}, 32'd1);
      op_i = o;
      a_i = x;
      b_i = y;
      in_valid_i = 1'b1;
      if (push) sb.push_back('{res: res, due: cyc + 1 + lat, name: name});
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(sb.size() == 0 && in_ready_o) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) check({name, "_timeout_pending"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  {31'b0, in_ready_o},  32'd1);
      check({tag, "_out_valid"}, {31'b0, out_valid_o}, 32'd0);
      check({tag, "_busy"},      {31'b0, busy_o},      32'd0);
      check({tag, "_result"},    result_o,             32'd0);
   endtask

   vec_t vecs[14] = '{
      '{"divu_100_7",    2'b01, 32'd100,        32'd7,          32'd14,         33},
      '{"remu_100_7",    2'b11, 32'd100,        32'd7,          32'd2,          33},
      '{"div_m7_2",      2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33},
      '{"rem_m7_2",      2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33},
      '{"rem_7_m2",      2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33},
      '{"div_m100_m7",   2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33},
      '{"divu_5_7",      2'b01, 32'd5,          32'd7,          32'd0,          33},
      '{"remu_max_10",   2'b11, 32'hFFFF_FFFF,  32'd10,         32'd5,          33},
      '{"divu_min_max",  2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33},
      '{"div_5_0",       2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  0},
      '{"remu_dead_0",   2'b11, 32'hDEAD_BEEF,  32'd0,          32'hDEAD_BEEF,  0},
      '{"rem_m5_0",      2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  0},
      '{"div_ovf",       2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0},
      '{"rem_ovf",       2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0}
   };

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
               checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_i = 1'b1;
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      op_i = 2'b00;
      a_i = '0;
      b_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset_i = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b1);
         wait_idle(vecs[i].name);
      end

      // Backpressure followed by an immediate second operation
      out_ready_i = 1'b0;
      issue("bp_divu_1000_9", 2'b01, 32'd1000, 32'd9, 32'd111, 33, 1'b1);
      for (int n = 0; n < 100 && !out_valid_o; n++) begin
         @(posedge clk);
         #1;
      end
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         check("bp_hold_result",    result_o,                32'd111);
         check("bp_hold_out_valid", {31'b0, out_valid_o},    32'd1);
         check("bp_hold_in_ready",  {31'b0, in_ready_o},     32'd0);
      end
      out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_in_ready", {31'b0, in_ready_o}, 32'd1);
      check("bp_release_popped",   32'(sb.size()),      32'd0);
      issue("b2b_div_m16_3", 2'b00, 32'hFFFF_FFF0, 32'd3, 32'hFFFF_FFFB, 33, 1'b1);
      wait_idle("b2b_div_m16_3");

      // Flush mid-CALC: the killed op must never present a result
      issue("flush_victim", 2'b01, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      check("flush_pre_busy", {31'b0, busy_o}, 32'd1);
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      check("flush_in_ready",  {31'b0, in_ready_o},  32'd1);
      check("flush_busy",      {31'b0, busy_o},      32'd0);
      check("flush_out_valid", {31'b0, out_valid_o}, 32'd0);
      repeat (40) begin
         @(posedge clk);
         #1;
      end
      // An offer coinciding with flush is dropped
      op_i = 2'b01;
      a_i = 32'd9;
      b_i = 32'd3;
      in_valid_i = 1'b1;
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      flush_i = 1'b0;
      check("flush_offer_in_ready", {31'b0, in_ready_o}, 32'd1);
      check("flush_offer_busy",     {31'b0, busy_o},     32'd0);
      issue("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33, 1'b1);
      wait_idle("divu_9_3");

      // Asynchronous reset mid-CALC, observed before the next clock edge
      issue("reset_victim", 2'b01, 32'd77, 32'd5, 32'd0, 0, 1'b0);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      #1;
      reset_i = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      issue("remu_77_5", 2'b11, 32'd77, 32'd5, 32'd2, 33, 1'b1);
      wait_idle("remu_77_5");

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_unit_32bit.md
# div_unit_32bit

Sequential RISC-V M-extension divider that executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm. Each iteration performs one trial subtraction, computed as an add with the subtrahend inverted and carry-in 1. The block sits beside the single-cycle adder/multiplier path in the execute stage and talks to issue and writeback through valid/ready handshakes. It accepts one operation at a time and supports a pipeline flush.

## Interface
- XLEN, 32: operand and result width.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous kill of any in-flight or completed operation.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept; equals (state == IDLE).
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- A  input  XLEN  dividend.
- B  input  XLEN  divisor.
- out_valid  output  1  Result is valid; equals (state == DONE).
- out_ready  input  1  consumer accepts Result.
- Result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
- busy  output  1  high in CALC, FIX or DONE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, Result 0, iteration counter 0.
- **Accept:** on `in_valid && in_ready`, latch op, A and B.
- **Operand preparation (signed ops):** store |A| and |B|. Record quotient sign = A[XLEN-1] ^ B[XLEN-1] and remainder sign = A[XLEN-1].
- **Unsigned ops:** operands are used raw and both signs are 0.
- **Special cases, checked at accept, go IDLE→DONE directly:**
  - B == 0: quotient all ones (0xFFFFFFFF); remainder = A unmodified.
  - Signed op with A == 0x80000000 and B == 0xFFFFFFFF: quotient 0x80000000; remainder 0.
- **Normal path, IDLE→CALC, counter loaded with XLEN-1:**
  - Partial remainder R is XLEN+1 bits, initially 0. Quotient register Q holds the dividend.
  - Each CALC cycle: shift {R,Q} left by 1, then trial T = R_shifted + ~{0,|B|} + 1.
  - If T is non-negative (bit XLEN = 0): R ← T and Q[0] ← 1. Otherwise R is kept and Q[0] ← 0.
  - Counter decrements each cycle. When it is 0 on an iteration, the next state is FIX.
- **FIX:** negate Q if the quotient sign is set. Negate R[XLEN-1:0] if the remainder sign is set. Select quotient or remainder by op into Result. Go to DONE.
- **DONE:** Result is held stable while out_valid is high. On `out_valid && out_ready`, go to IDLE, Result keeps its value and in_ready rises next cycle.
- **Priority:** reset > flush > handshake.
  - flush in any state: next state IDLE; out_valid low next cycle; the latched operation is discarded.
  - An in_valid offered in the same cycle as flush is not accepted.
- in_valid is ignored while in_ready is low. The upstream stage must hold op/A/B stable until accepted.

## Timing
- **Normal-op latency:** acceptance edge E0, XLEN CALC edges, one FIX edge. out_valid is high after edge E0+XLEN+1, i.e. 33 cycles for XLEN = 32.
- **Special-case latency:** out_valid is high after the acceptance edge, i.e. 1 cycle.
- **Throughput:** the earliest next accept is the cycle after the DONE handshake. There is no back-to-back overlap.
- **Backpressure:** out_ready low holds DONE indefinitely; Result and out_valid do not change.
- **Async reset mid-CALC:** outputs take their reset values immediately, without waiting for clk.
- **Combinational paths:** in_ready and out_valid are pure state decodes, so neither has a combinational path from in_valid or out_ready.

## Test plan
- DIVU: A = 100, B = 7, out_ready = 1. Expect Result = 14, out_valid exactly 33 cycles after accept. REMU with the same operands gives 2.
- Signed: DIV A = -7 (0xFFFFFFF9), B = 2 gives 0xFFFFFFFD (-3). REM gives 0xFFFFFFFF (-1). REM with A = 7, B = -2 gives 1.
- Divide by zero: DIV A = 5, B = 0 gives 0xFFFFFFFF after 1 cycle. REMU A = 0xDEADBEEF, B = 0 gives 0xDEADBEEF.
- Overflow: DIV A = 0x80000000, B = 0xFFFFFFFF gives 0x80000000. REM with the same operands gives 0. Both complete after 1 cycle.
- Backpressure and back-to-back:
  - Hold out_ready = 0 for 10 cycles in DONE. Result stays stable and in_ready stays 0.
  - Release out_ready; in_ready = 1 the next cycle.
  - A second op accepted immediately completes correctly.
- Flush and reset:
  - Assert flush at CALC iteration 10. IDLE follows next cycle, no out_valid appears, and a new DIVU 9/3 gives 3.
  - Assert reset asynchronously mid-CALC. All outputs take reset values before the next clock edge.
